// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional perf counters are enabled with HAZARD_PERF_CNT_EN.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2
  } hz_state_e;

  localparam int REG_AW_DEF = 5;
  localparam int X0_IDX     = 0;
  localparam int CNT_W      = $clog2(8);

endpackage

// File: rtl/hazard_ctrl_unit_match.sv
// Source/destination register comparator.
// x0 never hazards; unused sources are ignored.
import hazard_pkg::*;

module hazard_ctrl_unit_match #(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [REG_AW-1:0] rd,
  output logic              hit
);

  localparam logic [REG_AW-1:0] X0 = REG_AW'(X0_IDX);

  logic hit1, hit2;

  assign hit1 = rs1_used && (rs1 != X0) && (rs1 == rd);
  assign hit2 = rs2_used && (rs2 != X0) && (rs2 == rd);
  assign hit  = hit1 || hit2;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Clocked hazard FSM: load-use bubbles, branch flush, cache freeze.
// Define HAZARD_PERF_CNT_EN to build the bubble/flush perf counters.
import hazard_pkg::*;

module hazard_ctrl_unit #(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LOAD_LAT = 1,
  parameter int BR_EXTRA = 0,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_memread,
  input  logic              branch_taken,
  input  logic              icache_stall,
  input  logic              dcache_stall,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              freeze_all,
  output logic [PERF_W-1:0] perf_lu_cnt,
  output logic [PERF_W-1:0] perf_br_cnt
);

  localparam logic [CNT_W-1:0] LU_INIT = CNT_W'(LOAD_LAT - 2);
  localparam logic [CNT_W-1:0] BR_INIT = CNT_W'(BR_EXTRA - 1);
  localparam logic [CNT_W-1:0] CNT_0   = '0;
  localparam logic [CNT_W-1:0] CNT_1   = CNT_W'(1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_hit, mem_hit, lu_hit, freeze;
  logic stall_c, fl_ifid_c, fl_idex_c;

  hazard_ctrl_unit_match #(.REG_AW(REG_AW)) u_ex_match (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .rd       (ex_rd),
    .hit      (ex_hit)
  );

  hazard_ctrl_unit_match #(.REG_AW(REG_AW)) u_mem_match (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .rd       (mem_rd),
    .hit      (mem_hit)
  );

  assign freeze = icache_stall || dcache_stall;
  assign lu_hit = (ex_memread && ex_hit) ||
                  ((LOAD_LAT > 1) && mem_memread && mem_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    fl_ifid_c = 1'b0;
    fl_idex_c = 1'b0;
    if (!freeze) begin
      unique case (state_q)
        IDLE, LU_STALL: begin
          if (branch_taken) begin
            fl_ifid_c = 1'b1;
            fl_idex_c = 1'b1;
            if (BR_EXTRA > 0) begin
              state_d = BR_FLUSH;
              cnt_d   = BR_INIT;
            end else begin
              state_d = IDLE;
            end
          end else if (state_q == LU_STALL) begin
            stall_c   = 1'b1;
            fl_idex_c = 1'b1;
            if (cnt_q == CNT_0) state_d = IDLE;
            else cnt_d = cnt_q - CNT_1;
          end else if (lu_hit) begin
            stall_c   = 1'b1;
            fl_idex_c = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LU_STALL;
              cnt_d   = LU_INIT;
            end
          end
        end
        BR_FLUSH: begin
          fl_ifid_c = 1'b1;
          if (cnt_q == CNT_0) state_d = IDLE;
          else cnt_d = cnt_q - CNT_1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Reset forces every control low at once, regardless of inputs.
  assign freeze_all  = rst_n && freeze;
  assign stall_pc    = rst_n && (freeze || stall_c);
  assign stall_if_id = rst_n && (freeze || stall_c);
  assign flush_if_id = rst_n && fl_ifid_c;
  assign flush_id_ex = rst_n && fl_idex_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] lu_q, br_q;
  logic              lu_ev, br_ev;

  assign lu_ev = !freeze && stall_c && fl_idex_c;
  assign br_ev = !freeze && fl_ifid_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_q <= '0;
      br_q <= '0;
    end else begin
      if (lu_ev && (lu_q != '1)) lu_q <= lu_q + PERF_W'(1);
      if (br_ev && (br_q != '1)) br_q <= br_q + PERF_W'(1);
    end
  end

  assign perf_lu_cnt = lu_q;
  assign perf_br_cnt = br_q;
`else
  assign perf_lu_cnt = '0;
  assign perf_br_cnt = '0;
`endif

endmodule
